// File: rtl/fx2_pkg.sv
// Shared constants for the FX2 slave-FIFO responder: endpoint FIFO
// addresses and bit positions inside fx2_flags.
package fx2_pkg;

  // Endpoint select values on fx2_fifo_addr
  localparam logic [1:0] EP2 = 2'd0;  // OUT endpoint, host -> FPGA
  localparam logic [1:0] EP6 = 2'd2;  // IN endpoint, FPGA -> host

  // Bit positions inside fx2_flags
  localparam int FLAG_EP2_EMPTY_N = 0;
  localparam int FLAG_EP6_FULL_N  = 1;
  localparam int FLAG_ERROR       = 2;

endpackage

// File: rtl/fx2_ep_fifo.sv
// Synchronous first-word-fall-through FIFO used for each FX2 endpoint.
// The head word is always visible on 'head'; push into a full FIFO and
// pop from an empty FIFO are ignored. 'count' is the registered occupancy.
module fx2_ep_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count_reg != FULL_COUNT);
  assign pop_ok  = pop && (count_reg != '0);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage array; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/fx2_slave_fifo_resp.sv
// Behavioural responder modelling the FX2 side of the slave-FIFO bus.
// EP2 carries host data to the FPGA; EP6 carries FPGA data to the host in
// packets that become visible only once committed (auto-commit at
// PKT_WORDS or on PKTEND). Define FX2_SLAVE_FIFO_ZLP_EN to let a PKTEND
// with nothing pending queue a zero-length packet (host_in_zlp pulse).
module fx2_slave_fifo_resp
  import fx2_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PKT_WORDS = 8
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic        fx2_sloe_b,
  input  logic        fx2_slrd_b,
  input  logic        fx2_slwr_b,
  input  logic        fx2_pktend_b,
  input  logic [1:0]  fx2_fifo_addr,
  input  logic [15:0] fd_i,
  output logic [15:0] fd_o,
  output logic        fd_oe,
  output logic [2:0]  fx2_flags,
  input  logic [15:0] host_out_data,
  input  logic        host_out_valid,
  output logic        host_out_ready,
  output logic [15:0] host_in_data,
  output logic        host_in_valid,
  output logic        host_in_last,
  input  logic        host_in_ready,
  output logic        host_in_zlp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] PKT_CNT  = CW'(PKT_WORDS);

  logic [15:0]   ep2_head;
  logic [15:0]   ep6_head;
  logic [CW-1:0] ep2_count;
  logic [CW-1:0] ep6_count;
  logic          ep2_empty;
  logic          ep2_full;
  logic          ep6_full;
  logic          ep2_rd;
  logic          ep2_pop;
  logic          ep2_push;
  logic          ep6_wr;
  logic          ep6_push;
  logic          ep6_pktend;
  logic          host_pop;

  logic [CW-1:0] uncommitted_reg;
  logic [CW-1:0] uncommitted_plus;
  logic          data_commit;
  logic          zlp_commit;
  logic          zlp_head;

  // Packet length FIFO: one entry per committed packet
  logic [CW-1:0] lf_mem [DEPTH];
  logic [AW-1:0] lf_wr_ptr_reg;
  logic [AW-1:0] lf_rd_ptr_reg;
  logic [CW-1:0] lf_count_reg;
  logic [CW-1:0] lf_head;
  logic          lf_push;
  logic          lf_pop;
  logic          lf_full;
  logic          lf_empty;

  logic [CW-1:0] rd_idx_reg;
  logic          err_reg;

  // ---------------- EP2: host -> FPGA ----------------
  assign ep2_empty      = (ep2_count == '0);
  assign ep2_full       = (ep2_count == FULL_CNT);
  assign ep2_rd         = !fx2_slrd_b && (fx2_fifo_addr == EP2);
  assign ep2_pop        = ep2_rd && !ep2_empty;
  assign ep2_push       = host_out_valid && !ep2_full;
  assign host_out_ready = !ep2_full;
  assign fd_o           = ep2_empty ? '0 : ep2_head;
  assign fd_oe          = !reset && !fx2_sloe_b && (fx2_fifo_addr == EP2);

  fx2_ep_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_ep2 (
    .clk       (ifclk),
    .rst       (reset),
    .push      (ep2_push),
    .push_data (host_out_data),
    .pop       (ep2_pop),
    .head      (ep2_head),
    .count     (ep2_count)
  );

  // ---------------- EP6: FPGA -> host ----------------
  // The EP6 FIFO holds committed and uncommitted words alike, so its
  // occupancy is the full condition the FPGA sees.
  assign ep6_full   = (ep6_count == FULL_CNT);
  assign ep6_wr     = !fx2_slwr_b && (fx2_fifo_addr == EP6);
  assign ep6_push   = ep6_wr && !ep6_full;
  assign ep6_pktend = !fx2_pktend_b && (fx2_fifo_addr == EP6);

  // Uncommitted count including a write landing on this edge
  assign uncommitted_plus = uncommitted_reg + CW'(ep6_push);
  assign data_commit = (ep6_push && (uncommitted_plus == PKT_CNT)) ||
                       (ep6_pktend && (uncommitted_plus != '0));

  assign lf_full  = (lf_count_reg == FULL_CNT);
  assign lf_empty = (lf_count_reg == '0);
  assign lf_head  = lf_mem[lf_rd_ptr_reg];

`ifdef FX2_SLAVE_FIFO_ZLP_EN
  // A zero-length entry is simply dropped if the length FIFO is full
  assign zlp_commit = ep6_pktend && (uncommitted_plus == '0) && !lf_full;
  assign zlp_head   = !lf_empty && (lf_head == '0);
`else
  assign zlp_commit = 1'b0;
  assign zlp_head   = 1'b0;
`endif

  assign lf_push = (data_commit || zlp_commit) && !lf_full;

  // Host sees data only while a non-empty packet sits at the length head
  assign host_in_valid = !lf_empty && (lf_head != '0);
  assign host_in_last  = host_in_valid && (rd_idx_reg == (lf_head - CW'(1)));
  assign host_in_data  = host_in_valid ? ep6_head : '0;
  assign host_in_zlp   = zlp_head;
  assign host_pop      = host_in_valid && host_in_ready;
  assign lf_pop        = (host_pop && host_in_last) || zlp_head;

  fx2_ep_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_ep6 (
    .clk       (ifclk),
    .rst       (reset),
    .push      (ep6_push),
    .push_data (fd_i),
    .pop       (host_pop),
    .head      (ep6_head),
    .count     (ep6_count)
  );

  // Length FIFO storage, written with the length of each commit
  always_ff @(posedge ifclk) begin
    if (lf_push) begin
      lf_mem[lf_wr_ptr_reg] <= uncommitted_plus;
    end
  end

  // Length FIFO pointers and occupancy
  always_ff @(posedge ifclk) begin
    if (reset) begin
      lf_wr_ptr_reg <= '0;
      lf_rd_ptr_reg <= '0;
      lf_count_reg  <= '0;
    end else begin
      if (lf_push) lf_wr_ptr_reg <= lf_wr_ptr_reg + AW'(1);
      if (lf_pop)  lf_rd_ptr_reg <= lf_rd_ptr_reg + AW'(1);
      lf_count_reg <= lf_count_reg + CW'(lf_push) - CW'(lf_pop);
    end
  end

  // Commit tracking, host read position within packet, sticky error
  always_ff @(posedge ifclk) begin
    if (reset) begin
      uncommitted_reg <= '0;
      rd_idx_reg      <= '0;
      err_reg         <= 1'b0;
    end else begin
      uncommitted_reg <= data_commit ? '0 : uncommitted_plus;
      if (host_pop) begin
        rd_idx_reg <= host_in_last ? '0 : rd_idx_reg + CW'(1);
      end
      if ((ep2_rd && ep2_empty) || (ep6_wr && ep6_full)) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Flags follow registered occupancy, so they reflect the post-edge state
  assign fx2_flags[FLAG_EP2_EMPTY_N] = !ep2_empty;
  assign fx2_flags[FLAG_EP6_FULL_N]  = !ep6_full;
  assign fx2_flags[FLAG_ERROR]       = err_reg;

endmodule
